// File: rtl/smart_home_zoned.sv
// smart_home_zoned: multi-zone hysteretic HVAC controller with a global mode,
// per-zone minimum-dwell anti-short-cycle timers, and an edge-detected
// lighting colour sequencer. All state is synchronous to clk.
module smart_home_zoned #(
  parameter int ZONES     = 4,
  parameter int TEMP_W    = 5,
  parameter int HEAT_ON   = 18,
  parameter int TARGET    = 20,
  parameter int COOL_ON   = 22,
  parameter int MIN_DWELL = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ZONES*TEMP_W-1:0]      temperature,
  input  logic [1:0]                   mode,
  input  logic                         button,
  output logic [ZONES-1:0]             heating,
  output logic [ZONES-1:0]             cooling,
  output logic [2:0]                   colour,
  output logic [$clog2(ZONES+1)-1:0]   active_zones
);

  localparam int CNT_W = $clog2(MIN_DWELL + 1);
  localparam int AZ_W  = $clog2(ZONES + 1);

  // Thresholds at full temperature width so every compare is unsigned.
  localparam logic [TEMP_W-1:0] HEAT_T   = TEMP_W'(HEAT_ON);
  localparam logic [TEMP_W-1:0] TARGET_T = TEMP_W'(TARGET);
  localparam logic [TEMP_W-1:0] COOL_T   = TEMP_W'(COOL_ON);
  localparam logic [CNT_W-1:0]  DWELL_LD = CNT_W'(MIN_DWELL - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAT = 2'd1,
    ST_COOL = 2'd2
  } state_e;

  state_e           state_q [ZONES];
  state_e           state_d [ZONES];
  logic [CNT_W-1:0] cnt_q   [ZONES];
  logic [CNT_W-1:0] cnt_d   [ZONES];
  logic [AZ_W-1:0]  active_q;
  logic [AZ_W-1:0]  active_d;
  logic [2:0]       colour_q;
  logic [2:0]       colour_d;
  logic             button_q;
  logic             button_d;

  logic             heat_ok_s;
  logic             cool_ok_s;
  logic             press_s;

  // Global mode decode: which active states the current mode permits.
  always_comb begin
    heat_ok_s = (mode == 2'b01) || (mode == 2'b10);
    cool_ok_s = (mode == 2'b01) || (mode == 2'b11);
  end

  // Per-zone next state and dwell counter; forced exits ignore the dwell timer.
  always_comb begin
    for (int i = 0; i < ZONES; i++) begin
      logic [TEMP_W-1:0] t;
      t          = temperature[i*TEMP_W +: TEMP_W];
      state_d[i] = state_q[i];
      if (cnt_q[i] != {CNT_W{1'b0}}) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end else begin
        cnt_d[i] = {CNT_W{1'b0}};
      end
      case (state_q[i])
        ST_IDLE: begin
          if (cnt_q[i] == {CNT_W{1'b0}}) begin
            if ((t <= HEAT_T) && heat_ok_s) begin
              state_d[i] = ST_HEAT;
            end else if ((t >= COOL_T) && cool_ok_s) begin
              state_d[i] = ST_COOL;
            end else begin
              state_d[i] = ST_IDLE;
            end
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_HEAT: begin
          if (!heat_ok_s) begin
            state_d[i] = ST_IDLE;
          end else if ((cnt_q[i] == {CNT_W{1'b0}}) && (t >= TARGET_T)) begin
            state_d[i] = ST_IDLE;
          end else begin
            state_d[i] = ST_HEAT;
          end
        end
        ST_COOL: begin
          if (!cool_ok_s) begin
            state_d[i] = ST_IDLE;
          end else if ((cnt_q[i] == {CNT_W{1'b0}}) && (t <= TARGET_T)) begin
            state_d[i] = ST_IDLE;
          end else begin
            state_d[i] = ST_COOL;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
        end
      endcase
      // Any state entry restarts the minimum-occupancy window.
      if (state_d[i] != state_q[i]) begin
        cnt_d[i] = DWELL_LD;
      end else begin
        cnt_d[i] = cnt_d[i];
      end
    end
  end

  // Actuator outputs decode straight from the registered zone states.
  always_comb begin
    for (int i = 0; i < ZONES; i++) begin
      heating[i] = (state_q[i] == ST_HEAT);
      cooling[i] = (state_q[i] == ST_COOL);
    end
  end

  // Popcount of currently active zones, registered so it lags state by one edge.
  always_comb begin
    active_d = {AZ_W{1'b0}};
    for (int i = 0; i < ZONES; i++) begin
      active_d = active_d + AZ_W'(heating[i] | cooling[i]);
    end
  end

  // Lighting sequencer: advance once per rising edge of the button level.
  always_comb begin
    button_d = button;
    press_s  = button && !button_q;
    if (press_s) begin
      if ((colour_q == 3'd0) || (colour_q == 3'd6) || (colour_q == 3'd7)) begin
        colour_d = 3'd1;
      end else begin
        colour_d = colour_q + 3'd1;
      end
    end else begin
      colour_d = colour_q;
    end
  end

  // State registers; reset wins over any pending transition or press.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ZONES; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= {CNT_W{1'b0}};
      end
      active_q <= {AZ_W{1'b0}};
      colour_q <= 3'd0;
      button_q <= 1'b0;
    end else begin
      for (int i = 0; i < ZONES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      active_q <= active_d;
      colour_q <= colour_d;
      button_q <= button_d;
    end
  end

  assign colour       = colour_q;
  assign active_zones = active_q;

endmodule

// File: tb/tb_smart_home_zoned.sv
// Directed self-checking bench for smart_home_zoned (default parameters).
module tb_smart_home_zoned;

  logic        clk;
  logic        rst;
  logic [19:0] temp_r;
  logic [1:0]  mode;
  logic        button;
  logic [3:0]  heating;
  logic [3:0]  cooling;
  logic [2:0]  colour;
  logic [2:0]  active_zones;

  int checks;
  int failures;

  smart_home_zoned dut (
    .clk          (clk),
    .rst          (rst),
    .temperature  (temp_r),
    .mode         (mode),
    .button       (button),
    .heating      (heating),
    .cooling      (cooling),
    .colour       (colour),
    .active_zones (active_zones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_temp(input int z, input logic [4:0] v);
    temp_r[z*5 +: 5] = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    mode   = 2'b00;
    button = 1'b0;
    temp_r = {5'd20, 5'd20, 5'd20, 5'd20};
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] exp_col [7];
    checks   = 0;
    failures = 0;
    exp_col  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};

    // Reset state
    do_reset();
    chk("reset_heating", {28'd0, heating}, 32'd0);
    chk("reset_cooling", {28'd0, cooling}, 32'd0);
    chk("reset_colour", {29'd0, colour}, 32'd0);
    chk("reset_active", {29'd0, active_zones}, 32'd0);

    // Heat and hold: dwell keeps HEATING to N+3, exit at N+4, cool at N+8
    mode = 2'b01;
    set_temp(0, 5'd17);
    step();                               // edge N
    chk("heat_start", {28'd0, heating}, 32'd1);
    set_temp(0, 5'd25);
    step();                               // N+1
    chk("active_lag", {29'd0, active_zones}, 32'd1);
    step();                               // N+2
    step();                               // N+3
    chk("heat_hold_n3", {28'd0, heating}, 32'd1);
    step();                               // N+4
    chk("heat_exit_n4", {28'd0, heating}, 32'd0);
    step();
    step();
    step();                               // N+7
    chk("cool_wait_n7", {28'd0, cooling}, 32'd0);
    step();                               // N+8
    chk("cool_start_n8", {28'd0, cooling}, 32'd1);

    // Hysteresis on zone 1
    do_reset();
    mode = 2'b01;
    set_temp(1, 5'd23);
    step();
    chk("hys_cool_start", {28'd0, cooling}, 32'd2);
    set_temp(1, 5'd21);
    for (int k = 0; k < 10; k++) step();
    chk("hys_cool_hold21", {28'd0, cooling}, 32'd2);
    set_temp(1, 5'd20);
    step();
    chk("hys_cool_stop20", {28'd0, cooling}, 32'd0);
    set_temp(1, 5'd19);
    for (int k = 0; k < 6; k++) step();
    chk("hys_no_heat19", {28'd0, heating}, 32'd0);
    chk("hys_no_cool19", {28'd0, cooling}, 32'd0);

    // Forced exit on zone 2 during dwell
    do_reset();
    mode = 2'b01;
    set_temp(2, 5'd17);
    step();
    chk("force_heat_start", {28'd0, heating}, 32'd4);
    step();                               // counter now 2
    chk("force_heat_dwell", {28'd0, heating}, 32'd4);
    mode = 2'b11;
    step();
    chk("force_exit", {28'd0, heating}, 32'd0);
    for (int k = 0; k < 6; k++) step();
    chk("force_no_restart", {28'd0, heating}, 32'd0);
    chk("force_no_cool", {28'd0, cooling}, 32'd0);

    // Mode off, all zones cold
    do_reset();
    temp_r = {5'd15, 5'd15, 5'd15, 5'd15};
    mode   = 2'b00;
    for (int k = 0; k < 5; k++) step();
    chk("off_no_heat", {28'd0, heating}, 32'd0);
    mode = 2'b01;
    step();
    chk("all_heat", {28'd0, heating}, 32'd15);
    chk("all_active_lag", {29'd0, active_zones}, 32'd0);
    step();
    chk("all_active", {29'd0, active_zones}, 32'd4);

    // Lighting: single presses, wrap, then a held press
    do_reset();
    chk("light_reset", {29'd0, colour}, 32'd0);
    for (int k = 0; k < 7; k++) begin
      button = 1'b1;
      step();
      chk($sformatf("light_press%0d", k), {29'd0, colour}, {29'd0, exp_col[k]});
      button = 1'b0;
      step();
    end
    button = 1'b1;
    step();
    chk("light_held_first", {29'd0, colour}, 32'd2);
    for (int k = 0; k < 4; k++) step();
    chk("light_held_end", {29'd0, colour}, 32'd2);
    button = 1'b0;
    step();
    chk("light_release", {29'd0, colour}, 32'd2);

    // Reset mid-run with heating zones and a coincident press
    do_reset();
    mode   = 2'b01;
    temp_r = {5'd15, 5'd15, 5'd15, 5'd15};
    step();
    step();
    chk("mid_pre_active", {29'd0, active_zones}, 32'd4);
    rst    = 1'b1;
    button = 1'b1;
    step();
    chk("mid_rst_heating", {28'd0, heating}, 32'd0);
    chk("mid_rst_colour", {29'd0, colour}, 32'd0);
    chk("mid_rst_active", {29'd0, active_zones}, 32'd0);
    rst    = 1'b0;
    button = 1'b0;
    temp_r = {5'd17, 5'd17, 5'd17, 5'd17};
    step();
    chk("mid_reheat", {28'd0, heating}, 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
